// File: rtl/axicb_pkg.sv
// ----------------------------------------------------------------------------
// axicb_pkg
// Shared types and constants for the AXI crossbar completion path.
//   cpl_state_t : completion switch FSM states
//   RESP_*      : AXI response encodings used by the switch
//   cch_width() : width of a completion channel {id,resp[,data]}
// ----------------------------------------------------------------------------
package axicb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FWD    = 2'd1,
      DECERR = 2'd2
   } cpl_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // R channel carries {id,resp,data}; B channel carries {id,resp}.
   function automatic int cch_width(input int rd_path, input int id_w, input int data_w);
      return (rd_path != 0) ? (id_w + 2 + data_w) : (id_w + 2);
   endfunction

endpackage

// File: rtl/axicb_onehot_mux.sv
// ----------------------------------------------------------------------------
// axicb_onehot_mux
// One-hot select of N inputs of W bits each. An all-zero select yields zero.
//   sel  in  N    one-hot select
//   din  in  N*W  concatenated inputs, input i at din[i*W +: W]
//   dout out W    selected input
// ----------------------------------------------------------------------------
module axicb_onehot_mux #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic [N-1:0]   sel,
   input  logic [N*W-1:0] din,
   output logic [W-1:0]   dout
);

   // NOTE: every output of an always_comb gets a default first so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      dout = '0;
      for (int i = 0; i < N; i++) begin
         if (sel[i]) dout = dout | din[i*W +: W];
      end
   end

endmodule

// File: rtl/axicb_slv_cpl_switch.sv
// ----------------------------------------------------------------------------
// axicb_slv_cpl_switch
// Completion switch for one master port. Latches the arbiter's grant for one
// whole completion, forwards the granted slave's R/B channel to the master,
// and generates DECERR completions for misrouted requests.
//   aclk, arst          clock, asynchronous active-high reset
//   c_en                arbiter enable, high only while idle
//   c_grant/mr/len/id   grant and attributes from the arbiter
//   c_ready             arbiter FIFO pull, on the master's last-beat handshake
//   s_valid/ready/last  per-slave completion handshake (last used on R only)
//   s_ch                per-slave channels, slave i at s_ch[i*CCH_W +: CCH_W]
//   m_valid/ready/last  master completion handshake
//   m_ch                master channel {id,resp[,data]}
//   len_err             pulse on a beat that disagrees with the granted ALEN
// ----------------------------------------------------------------------------
module axicb_slv_cpl_switch
   import axicb_pkg::*;
#(
   parameter  int RD_PATH    = 0,
   parameter  int AXI_ID_W   = 8,
   parameter  int AXI_DATA_W = 32,
   parameter  int SLV_NB     = 4,
   localparam int CCH_W      = cch_width(RD_PATH, AXI_ID_W, AXI_DATA_W)
) (
   input  logic                    aclk,
   input  logic                    arst,
   output logic                    c_en,
   input  logic [SLV_NB-1:0]       c_grant,
   input  logic                    c_mr,
   input  logic [7:0]              c_len,
   input  logic [AXI_ID_W-1:0]     c_id,
   output logic                    c_ready,
   input  logic [SLV_NB-1:0]       s_valid,
   output logic [SLV_NB-1:0]       s_ready,
   input  logic [SLV_NB-1:0]       s_last,
   input  logic [CCH_W*SLV_NB-1:0] s_ch,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic [CCH_W-1:0]        m_ch,
   output logic                    len_err
);

   cpl_state_t          state;
   logic [SLV_NB-1:0]   grant_q;
   logic [7:0]          len_q;
   logic [AXI_ID_W-1:0] id_q;
   logic [7:0]          cnt;
   logic [7:0]          cnt_inc;

   logic [CCH_W-1:0]    sel_ch;
   logic                sel_last;
   logic [CCH_W-1:0]    decerr_ch;
   logic                hs;

   axicb_onehot_mux #(.N(SLV_NB), .W(CCH_W)) u_ch_mux (
      .sel  (grant_q),
      .din  (s_ch),
      .dout (sel_ch)
   );

   axicb_onehot_mux #(.N(SLV_NB), .W(1)) u_last_mux (
      .sel  (grant_q),
      .din  (s_last),
      .dout (sel_last)
   );

   // Saturating beat count; DECERR compares before incrementing, so a
   // 256-beat burst ends on cnt==255 without wrapping.
   assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   // {id_q, DECERR, zero data}; the id field sits at the top of the channel.
   always_comb begin
      decerr_ch = '0;
      decerr_ch[CCH_W-1 -: AXI_ID_W]    = id_q;
      decerr_ch[CCH_W-AXI_ID_W-1 -: 2]  = RESP_DECERR;
   end

   // Outputs decode from the registered state; FWD is a pure mux path so
   // there is no added latency between slave and master.
   always_comb begin
      c_en    = 1'b0;
      s_ready = '0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_ch    = '0;
      len_err = 1'b0;
      case (state)
         IDLE: begin
            c_en = 1'b1;
         end
         FWD: begin
            m_valid = |(s_valid & grant_q);
            m_ch    = sel_ch;
            s_ready = grant_q & {SLV_NB{m_ready}};
            m_last  = (RD_PATH != 0) ? sel_last : 1'b1;
            // A short burst errs on its last beat; a long one errs on the
            // beat that should have been last (cnt passes len_q afterwards).
            if (RD_PATH != 0 && m_valid && m_ready)
               len_err = sel_last ? (cnt != len_q) : (cnt == len_q);
         end
         DECERR: begin
            m_valid = 1'b1;
            m_ch    = decerr_ch;
            m_last  = (RD_PATH != 0) ? (cnt == len_q) : 1'b1;
         end
         default: ;
      endcase
      hs      = m_valid & m_ready;
      c_ready = hs & m_last;
   end

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state   <= IDLE;
         grant_q <= '0;
         len_q   <= '0;
         id_q    <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (c_mr) begin
                  len_q <= c_len;
                  id_q  <= c_id;
                  cnt   <= '0;
                  state <= DECERR;
               end else if (|c_grant) begin
                  grant_q <= c_grant;
                  len_q   <= c_len;
                  id_q    <= c_id;
                  cnt     <= '0;
                  state   <= FWD;
               end
            end
            FWD: begin
               if (hs) begin
                  cnt <= cnt_inc;
                  if (RD_PATH == 0 || sel_last) state <= IDLE;
               end
            end
            DECERR: begin
               if (hs) begin
                  cnt <= cnt_inc;
                  if (m_last) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axicb_slv_cpl_switch.sv
// ----------------------------------------------------------------------------
// tb_axicb_slv_cpl_switch
// Directed bench for the completion switch: one R-path and one B-path
// instance share the clock and reset. Inputs change 1 ns after the rising
// edge; outputs are compared 1 ns later, mid-cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axicb_slv_cpl_switch;

   localparam int NB  = 4;
   localparam int RCW = 8 + 2 + 32;
   localparam int WCW = 8 + 2;

   logic aclk = 1'b0;
   logic arst;
   always #5 aclk = ~aclk;

   // R-path instance
   logic           r_c_en, r_c_mr, r_c_ready;
   logic [NB-1:0]  r_c_grant, r_s_valid, r_s_ready, r_s_last;
   logic [7:0]     r_c_len, r_c_id;
   logic [RCW*NB-1:0] r_s_ch;
   logic           r_m_valid, r_m_ready, r_m_last, r_len_err;
   logic [RCW-1:0] r_m_ch;

   // B-path instance
   logic           w_c_en, w_c_mr, w_c_ready;
   logic [NB-1:0]  w_c_grant, w_s_valid, w_s_ready, w_s_last;
   logic [7:0]     w_c_len, w_c_id;
   logic [WCW*NB-1:0] w_s_ch;
   logic           w_m_valid, w_m_ready, w_m_last, w_len_err;
   logic [WCW-1:0] w_m_ch;

   axicb_slv_cpl_switch #(.RD_PATH(1), .AXI_ID_W(8), .AXI_DATA_W(32), .SLV_NB(NB)) dut_rd (
      .aclk(aclk), .arst(arst),
      .c_en(r_c_en), .c_grant(r_c_grant), .c_mr(r_c_mr), .c_len(r_c_len),
      .c_id(r_c_id), .c_ready(r_c_ready),
      .s_valid(r_s_valid), .s_ready(r_s_ready), .s_last(r_s_last), .s_ch(r_s_ch),
      .m_valid(r_m_valid), .m_ready(r_m_ready), .m_last(r_m_last), .m_ch(r_m_ch),
      .len_err(r_len_err)
   );

   axicb_slv_cpl_switch #(.RD_PATH(0), .AXI_ID_W(8), .AXI_DATA_W(32), .SLV_NB(NB)) dut_wr (
      .aclk(aclk), .arst(arst),
      .c_en(w_c_en), .c_grant(w_c_grant), .c_mr(w_c_mr), .c_len(w_c_len),
      .c_id(w_c_id), .c_ready(w_c_ready),
      .s_valid(w_s_valid), .s_ready(w_s_ready), .s_last(w_s_last), .s_ch(w_s_ch),
      .m_valid(w_m_valid), .m_ready(w_m_ready), .m_last(w_m_last), .m_ch(w_m_ch),
      .len_err(w_len_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [RCW-1:0] rch(input logic [7:0] id, input logic [1:0] resp,
                                          input logic [31:0] data);
      return {id, resp, data};
   endfunction

   task automatic clear_inputs();
      r_c_grant = '0; r_c_mr = 1'b0; r_c_len = '0; r_c_id = '0;
      r_s_valid = '0; r_s_last = '0; r_s_ch = '0; r_m_ready = 1'b0;
      w_c_grant = '0; w_c_mr = 1'b0; w_c_len = '0; w_c_id = '0;
      w_s_valid = '0; w_s_last = '0; w_s_ch = '0; w_m_ready = 1'b0;
   endtask

   // Drive one beat from read slave s and let the mux path settle.
   task automatic r_beat(input int s, input logic [31:0] data, input logic last);
      r_s_valid = '0; r_s_last = '0; r_s_ch = '0;
      r_s_valid[s] = 1'b1;
      r_s_last[s]  = last;
      r_s_ch[s*RCW +: RCW] = rch(8'h07, 2'b00, data);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ready_pulses;
      clear_inputs();
      arst = 1'b1;
      tick(); tick();

      // ---- reset state ----
      check("rst_c_en",    r_c_en, 1);
      check("rst_m_valid", r_m_valid, 0);
      check("rst_s_ready", r_s_ready, 0);
      check("rst_m_last",  r_m_last, 0);
      check("rst_m_ch",    r_m_ch, 0);
      check("rst_len_err", r_len_err, 0);
      check("rst_w_c_en",  w_c_en, 1);
      check("rst_w_m_ch",  w_m_ch, 0);
      arst = 1'b0;
      tick();

      // ---- read, slave 1, 4 beats, m_ready held high ----
      r_c_grant = 4'b0010; r_c_len = 8'd3; r_c_id = 8'h07;
      #1;
      check("t1_idle_c_en", r_c_en, 1);
      tick();
      r_c_grant = 4'b0100;   // ignored while busy
      r_m_ready = 1'b1;
      ready_pulses = 0;
      for (int b = 0; b < 4; b++) begin
         r_beat(1, 32'hA000_0000 + b, b == 3);
         check("t1_m_valid", r_m_valid, 1);
         check("t1_m_ch",    r_m_ch, rch(8'h07, 2'b00, 32'hA000_0000 + b));
         check("t1_m_last",  r_m_last, b == 3);
         check("t1_c_en",    r_c_en, 0);
         check("t1_s_ready", r_s_ready, 4'b0010);
         check("t1_len_err", r_len_err, 0);
         if (r_c_ready) ready_pulses++;
         tick();
      end
      check("t1_c_ready_pulses", ready_pulses, 1);
      clear_inputs();
      #1;
      check("t1_back_idle", r_c_en, 1);
      check("t1_idle_m_valid", r_m_valid, 0);
      tick();

      // ---- read misrouted, len 1, id 5, m_ready 1,0,1 ----
      r_c_mr = 1'b1; r_c_len = 8'd1; r_c_id = 8'h05; r_c_grant = 4'b0100;
      tick();
      clear_inputs();
      r_m_ready = 1'b1; #1;
      check("t2_b1_valid", r_m_valid, 1);
      check("t2_b1_ch",    r_m_ch, rch(8'h05, 2'b11, 32'h0));
      check("t2_b1_last",  r_m_last, 0);
      check("t2_b1_sready", r_s_ready, 0);
      check("t2_b1_c_ready", r_c_ready, 0);
      tick();
      r_m_ready = 1'b0; #1;
      check("t2_stall_valid", r_m_valid, 1);
      check("t2_stall_ch",    r_m_ch, rch(8'h05, 2'b11, 32'h0));
      check("t2_stall_last",  r_m_last, 1);
      check("t2_stall_c_ready", r_c_ready, 0);
      tick();
      r_m_ready = 1'b1; #1;
      check("t2_b2_valid", r_m_valid, 1);
      check("t2_b2_last",  r_m_last, 1);
      check("t2_b2_c_ready", r_c_ready, 1);
      tick();
      clear_inputs(); #1;
      check("t2_back_idle", r_c_en, 1);
      check("t2_idle_m_valid", r_m_valid, 0);
      tick();

      // ---- write, slave 3, B with id 0x2 ----
      w_c_grant = 4'b1000; w_c_id = 8'h09;
      tick();
      w_c_grant = '0;
      w_s_valid = 4'b1000; w_s_ch[3*WCW +: WCW] = {8'h02, 2'b00};
      w_m_ready = 1'b0; #1;
      check("t3_m_valid",  w_m_valid, 1);
      check("t3_m_ch",     w_m_ch, {8'h02, 2'b00});
      check("t3_m_last",   w_m_last, 1);
      check("t3_s_ready_lo", w_s_ready, 4'b0000);
      check("t3_c_ready_lo", w_c_ready, 0);
      w_m_ready = 1'b1; #1;
      check("t3_s_ready_hi", w_s_ready, 4'b1000);
      check("t3_c_ready_hi", w_c_ready, 1);
      tick();
      clear_inputs(); #1;
      check("t3_back_idle", w_c_en, 1);
      check("t3_idle_m_valid", w_m_valid, 0);
      tick();

      // ---- write misrouted: single DECERR beat ----
      w_c_mr = 1'b1; w_c_id = 8'h3C; w_c_len = 8'd4;
      tick();
      clear_inputs();
      w_m_ready = 1'b1; #1;
      check("t3d_m_ch",    w_m_ch, {8'h3C, 2'b11});
      check("t3d_m_last",  w_m_last, 1);
      check("t3d_c_ready", w_c_ready, 1);
      tick();
      clear_inputs(); #1;
      check("t3d_back_idle", w_c_en, 1);
      tick();

      // ---- length mismatch: len 3, last on beat 2 ----
      r_c_grant = 4'b0001; r_c_len = 8'd3;
      tick();
      r_c_grant = '0; r_m_ready = 1'b1;
      r_beat(0, 32'h1111_0000, 1'b0);
      check("t4_b1_len_err", r_len_err, 0);
      tick();
      r_beat(0, 32'h1111_0001, 1'b1);
      check("t4_b2_len_err", r_len_err, 1);
      check("t4_b2_m_ch",    r_m_ch, rch(8'h07, 2'b00, 32'h1111_0001));
      check("t4_b2_c_ready", r_c_ready, 1);
      tick();
      clear_inputs();
      r_c_grant = 4'b0100; r_c_len = 8'd0; #1;
      check("t4_idle_c_en",    r_c_en, 1);
      check("t4_idle_len_err", r_len_err, 0);
      tick();
      r_c_grant = '0; r_m_ready = 1'b1;
      r_beat(2, 32'h2222_0000, 1'b1);
      check("t4_next_m_valid", r_m_valid, 1);
      check("t4_next_m_ch",    r_m_ch, rch(8'h07, 2'b00, 32'h2222_0000));
      check("t4_next_len_err", r_len_err, 0);
      check("t4_next_c_ready", r_c_ready, 1);
      tick();
      clear_inputs(); tick();

      // ---- long burst: len 0 but slave sends 2 beats ----
      r_c_grant = 4'b0010; r_c_len = 8'd0;
      tick();
      r_c_grant = '0; r_m_ready = 1'b1;
      r_beat(1, 32'h3333_0000, 1'b0);
      check("t4l_b1_len_err", r_len_err, 1);
      check("t4l_b1_c_ready", r_c_ready, 0);
      tick();
      r_beat(1, 32'h3333_0001, 1'b1);
      check("t4l_b2_m_valid", r_m_valid, 1);
      check("t4l_b2_c_ready", r_c_ready, 1);
      tick();
      clear_inputs(); tick();

      // ---- misrouted len 255: 256 beats, no wrap ----
      r_c_mr = 1'b1; r_c_len = 8'd255; r_c_id = 8'hEE;
      tick();
      clear_inputs();
      r_m_ready = 1'b1; #1;
      for (int i = 0; i < 256; i++) begin
         check("t5_m_last", r_m_last, i == 255);
         tick();
      end
      #1;
      check("t5_back_idle", r_c_en, 1);
      check("t5_idle_m_valid", r_m_valid, 0);
      clear_inputs(); tick();

      // ---- reset mid-burst ----
      r_c_grant = 4'b0010; r_c_len = 8'd3;
      tick();
      r_c_grant = '0; r_m_ready = 1'b1;
      r_beat(1, 32'h4444_0000, 1'b0);
      check("t6_b1_m_valid", r_m_valid, 1);
      tick();
      r_beat(1, 32'h4444_0001, 1'b0);
      arst = 1'b1; #1;
      check("t6_rst_c_en",    r_c_en, 1);
      check("t6_rst_m_valid", r_m_valid, 0);
      check("t6_rst_s_ready", r_s_ready, 0);
      tick();
      check("t6_next_c_en",    r_c_en, 1);
      check("t6_next_m_valid", r_m_valid, 0);
      arst = 1'b0;
      clear_inputs();
      tick();
      r_c_grant = 4'b1000; r_c_len = 8'd0;
      tick();
      r_c_grant = '0; r_m_ready = 1'b1;
      r_beat(3, 32'h5555_0000, 1'b1);
      check("t6_fresh_m_valid", r_m_valid, 1);
      check("t6_fresh_m_ch",    r_m_ch, rch(8'h07, 2'b00, 32'h5555_0000));
      check("t6_fresh_s_ready", r_s_ready, 4'b1000);
      check("t6_fresh_c_ready", r_c_ready, 1);
      check("t6_fresh_len_err", r_len_err, 0);
      tick();
      clear_inputs(); #1;
      check("t6_back_idle", r_c_en, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
